// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and default width for the piso transmitter
package piso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} tx_state_t;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/tx_bit_counter.sv
// tx_bit_counter: loadable bit-index up-counter with terminal-count flag at WIDTH-1
module tx_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     tc
);
    localparam int CW = $clog2(WIDTH);
    always_ff @(posedge clk) begin
        if (rst || load) count <= '0;
        else if (inc) count <= count + CW'(1);
    end
    assign tc = count == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_tx.sv
// piso_tx: valid/ready parallel-in serial-out transmitter; PIPO_PARITY_EN appends an even-parity bit
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH);
    tx_state_t state, state_nx;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0] count;
    logic tc, last, xfer, inc, emit, bit_nx, done_nx;
`ifdef PIPO_PARITY_EN
    logic par;
    assign last = state == PARITY;
`else
    assign last = state == SHIFT && tc;
`endif
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction
    function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w << 1 : w >> 1;
    endfunction
    assign din_ready = !rst && (state == IDLE || last);
    assign xfer = din_valid && din_ready;
    tx_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (xfer),
        .inc  (inc),
        .count(count),
        .tc   (tc)
    );
    always_comb begin
        state_nx = IDLE;
        bit_nx = 1'b0;
        emit = 1'b0;
        done_nx = 1'b0;
        inc = 1'b0;
        if (xfer) begin
            state_nx = SHIFT;
            bit_nx = head(din);
            emit = 1'b1;
        end else if (state == SHIFT && !tc) begin
            state_nx = SHIFT;
            bit_nx = head(sr);
            emit = 1'b1;
            inc = 1'b1;
`ifndef PIPO_PARITY_EN
            done_nx = count == CW'(WIDTH - 2);
`endif
        end
`ifdef PIPO_PARITY_EN
        else if (state == SHIFT) begin
            state_nx = PARITY;
            bit_nx = par;
            emit = 1'b1;
            done_nx = 1'b1;
        end
`endif
    end
    // outputs are registered one step ahead: the bit loaded here is on sout next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr <= '0;
            sout <= 1'b0;
            sout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_nx;
            sout <= bit_nx;
            sout_valid <= emit;
            frame_done <= done_nx;
            if (xfer) sr <= shift(din);
            else if (inc) sr <= shift(sr);
        end
    end
`ifdef PIPO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par <= 1'b0;
        else if (xfer) par <= ^din;
    end
`endif
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: timeline-model checker for piso_tx in MSB-first and LSB-first builds
module tb_piso_tx;
    localparam int W = 4;
`ifdef PIPO_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif
    localparam int N = 4096;

    logic clk = 1'b0, rst = 1'b1, din_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic rdy_m, sout_m, sv_m, fd_m, rdy_l, sout_l, sv_l, fd_l;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .sout(sout_m), .sout_valid(sv_m), .frame_done(fd_m)
    );
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .sout(sout_l), .sout_valid(sv_l), .frame_done(fd_l)
    );

    always #5 clk = ~clk;

    // expected timeline: what each cycle must show, filled in when a word is accepted
    logic ev[N], ed[N], eb_m[N], eb_l[N];
    logic got_m[N], got_v[N], got_d[N], got_l[N], got_r[N];
    int cyc = 0, n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        chk(name, {31'b0, got}, {31'b0, exp});
    endtask

    function automatic logic [31:0] hist(input int sel, input int s, input int n);
        logic [31:0] r;
        logic b;
        r = '0;
        for (int i = 0; i < n; i++) begin
            case (sel)
                0: b = got_m[s+i];
                1: b = got_v[s+i];
                2: b = got_d[s+i];
                3: b = got_l[s+i];
                default: b = got_r[s+i];
            endcase
            r = {r[30:0], b};
        end
        return r;
    endfunction

    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        logic exp_r;
        rst = r;
        din_valid = v;
        din = d;
        @(negedge clk);
        exp_r = !r && !ev[cyc+1];
        chk1("sout_valid", sv_m, ev[cyc]);
        chk1("sout", sout_m, eb_m[cyc]);
        chk1("frame_done", fd_m, ed[cyc]);
        chk1("din_ready", rdy_m, exp_r);
        chk1("lsb sout_valid", sv_l, ev[cyc]);
        chk1("lsb sout", sout_l, eb_l[cyc]);
        chk1("lsb frame_done", fd_l, ed[cyc]);
        chk1("lsb din_ready", rdy_l, exp_r);
        got_m[cyc] = sout_m;
        got_v[cyc] = sv_m;
        got_d[cyc] = fd_m;
        got_l[cyc] = sout_l;
        got_r[cyc] = rdy_m;
        if (r) begin
            for (int i = cyc + 1; i < cyc + F + 2; i++) begin
                ev[i] = 1'b0; ed[i] = 1'b0; eb_m[i] = 1'b0; eb_l[i] = 1'b0;
            end
        end else if (v && exp_r) begin
            for (int k = 0; k < F; k++) begin
                ev[cyc+1+k] = 1'b1;
                ed[cyc+1+k] = k == F - 1;
                eb_m[cyc+1+k] = k < W ? d[W-1-k] : ^d;
                eb_l[cyc+1+k] = k < W ? d[k] : ^d;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        int c;
        for (int i = 0; i < N; i++) begin
            ev[i] = 1'b0; ed[i] = 1'b0; eb_m[i] = 1'b0; eb_l[i] = 1'b0;
            got_m[i] = 1'b0; got_v[i] = 1'b0; got_d[i] = 1'b0; got_l[i] = 1'b0; got_r[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 4'hA);
        idle(2);

        c = cyc;
        step(1'b0, 1'b1, 4'b1011);
        idle(F + 2);
`ifdef PIPO_PARITY_EN
        chk("single frame bits", hist(0, c + 1, 5), 'b10111);
        chk("single frame done", hist(2, c + 1, 6), 'b000010);
        chk("single frame valid", hist(1, c + 1, 6), 'b111110);
        chk("lsb frame bits", hist(3, c + 1, 5), 'b11011);
`else
        chk("single frame bits", hist(0, c + 1, 4), 'b1011);
        chk("single frame done", hist(2, c + 1, 5), 'b00010);
        chk("single frame valid", hist(1, c + 1, 5), 'b11110);
        chk("lsb frame bits", hist(3, c + 1, 4), 'b1101);
`endif

        c = cyc;
        step(1'b0, 1'b1, 4'b1011);
        for (int i = 0; i < F; i++) step(1'b0, 1'b1, 4'b0110);
        idle(F + 2);
`ifdef PIPO_PARITY_EN
        chk("b2b bits", hist(0, c + 1, 10), 'b1011101100);
        chk("b2b ready", hist(4, c, 10), 'b1000010000);
`else
        chk("b2b bits", hist(0, c + 1, 8), 'b10110110);
        chk("b2b ready", hist(4, c, 8), 'b10001000);
`endif

        c = cyc;
        step(1'b0, 1'b1, 4'h5);
        for (int i = 0; i < F; i++) step(1'b0, 1'b1, 4'hF);
        idle(F + 2);
        chk("backpressure bits", hist(0, c + 1, 4), 'b0101);
        chk("held word bits", hist(0, c + F + 1, 4), 'b1111);

        c = cyc;
        step(1'b0, 1'b1, 4'b1011);
        idle(2);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 4'b0110);
        idle(F + 2);
        chk("reset abort valid", hist(1, c + 1, 6), 'b111011);
        chk("ready after reset", hist(4, c + 4, 1), 'b1);
        chk("frame after reset", hist(0, c + 5, 4), 'b0110);

        for (int i = 0; i < 1200; i++)
            step($urandom_range(99) == 0, $urandom_range(2) != 0, W'($urandom));
        idle(F + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
